// File: rtl/req_arbiter8_pkg.sv
// Shared definitions for the eight-way request/grant arbiter.
package req_arbiter8_pkg;

  localparam int NREQ = 8;
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arbState_e;

endpackage

// File: rtl/req_arbiter8_pri_enc8.sv
// 8-to-3 priority encoder: reports the highest set index of the input vector.
module pri_enc8
  import req_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0] vec_i,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  // Scan upward so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (vec_i[i]) begin
        idx_o = ID_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/req_arbiter8.sv
// Eight-input arbiter with registered one-hot grants, optional round-robin,
// hold-until-release ownership, a turnaround cycle and a hold timeout that
// locks the offending requester out until it drops its request.
module req_arbiter8
  import req_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            rr_en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  // A zero limit turns the timeout off entirely.
  localparam bit              TimeoutEn = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] MaxHoldC = CNT_W'(MAX_HOLD);

  arbState_e       state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] gntId_q, gntId_d;
  logic [ID_W-1:0] lastId_q, lastId_d;
  logic [NREQ-1:0] blocked_q, blocked_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] lowerMask;
  logic [NREQ-1:0] masked;
  logic [ID_W-1:0] eligIdx, maskedIdx, winner;
  logic            eligAny, maskedAny;
  logic            holdAtLimit;

  // Round-robin looks first at requesters strictly below the last winner,
  // wrapping to the full eligible set when none of those are asking.
  assign elig      = req & ~blocked_q;
  assign lowerMask = (NREQ'(1) << lastId_q) - NREQ'(1);
  assign masked    = elig & lowerMask;

  pri_enc8 uEncMasked (
    .vec_i (masked),
    .idx_o (maskedIdx),
    .any_o (maskedAny)
  );

  pri_enc8 uEncElig (
    .vec_i (elig),
    .idx_o (eligIdx),
    .any_o (eligAny)
  );

  assign winner      = (rr_en && maskedAny) ? maskedIdx : eligIdx;
  assign holdAtLimit = TimeoutEn && (holdCnt_q == MaxHoldC);

  // Next-state and next-output logic; arbitration only happens from IDLE or
  // RELEASE, so the owner is never preempted and rr_en only matters there.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gntId_d   = gntId_q;
    lastId_d  = lastId_q;
    holdCnt_d = holdCnt_q;
    timeout_d = 1'b0;
    blocked_d = blocked_q & req;

    case (state_q)
      GRANT: begin
        if (!req[gntId_q]) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          gntId_d   = '0;
          holdCnt_d = '0;
        end else if (holdAtLimit) begin
          state_d            = RELEASE;
          gnt_d              = '0;
          gntId_d            = '0;
          holdCnt_d          = '0;
          blocked_d[gntId_q] = 1'b1;
          timeout_d          = 1'b1;
        end else if (holdCnt_q != '1) begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end

      default: begin
        if (eligAny) begin
          state_d   = GRANT;
          gnt_d     = NREQ'(1) << winner;
          gntId_d   = winner;
          lastId_d  = winner;
          holdCnt_d = CNT_W'(1);
        end else begin
          state_d   = IDLE;
          gnt_d     = '0;
          gntId_d   = '0;
          holdCnt_d = '0;
        end
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gntId_q   <= '0;
      lastId_q  <= '0;
      blocked_q <= '0;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      lastId_q  <= lastId_d;
      blocked_q <= blocked_d;
      holdCnt_q <= holdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gntId_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/req_arbiter8.md
# req_arbiter8

Eight-input request/grant arbiter that shares one downstream resource among eight requesters. It uses the team's 8-to-3 priority encoding (highest index wins) as its decision core. It adds registered grants, a selectable round-robin mode, ownership hold until release, a bus-turnaround cycle, and a hold-timeout with requester lockout. It sits between the requester ports and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive GRANT cycles per ownership, range 1..255. Value 0 disables the timeout.
- `CNT_W`, default 8: width of the hold counter. Must hold `MAX_HOLD`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  8  per-requester request, level. Held high for as long as ownership is wanted.
- `rr_en`  in  1  1 = round-robin, 0 = fixed priority (bit 7 highest). Sampled only at arbitration edges.
- `gnt`  out  8  one-hot grant, registered; all zeros when no owner.
- `gnt_id`  out  3  index of the owner; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  high while a requester owns the resource.
- `timeout`  out  1  one-cycle pulse when an ownership is force-ended.

## Operation
- Eligible set: `elig = req & ~blocked`.
- Fixed mode: the winner is the highest set index of `elig`.
- Round-robin mode:
  - `masked = elig` restricted to indices strictly below `last_id`.
  - If `masked` is non-zero, the winner is the highest set index of `masked`; otherwise it is the highest set index of `elig`.
  - `last_id` updates to the winner on every grant.
- State machine, three states: IDLE, GRANT, RELEASE.
  - IDLE: if `elig` ≠ 0, go to GRANT. Load `gnt`/`gnt_id` with the winner and set `hold_cnt` = 1. Otherwise stay in IDLE.
  - GRANT, normal release: if `req[gnt_id]` = 0, go to RELEASE.
  - GRANT, timeout: if `MAX_HOLD` ≠ 0, `hold_cnt` = `MAX_HOLD`, and `req[gnt_id]` = 1, go to RELEASE. Set `blocked[gnt_id]` and assert `timeout` for the RELEASE cycle.
  - GRANT, otherwise: stay in GRANT and increment `hold_cnt`. The counter saturates; it never wraps.
  - RELEASE: `gnt` = 0, `gnt_valid` = 0 for exactly one cycle. Arbitration is then evaluated as in IDLE, so RELEASE goes to GRANT or IDLE.
- `blocked[i]` clears on any edge where `req[i]` is sampled 0. A timed-out requester must drop its request for at least one cycle before it is eligible again.
- Requests from non-owners during GRANT are ignored; there is no preemption.
- A change in `rr_en` during GRANT has no effect until the next arbitration edge.

## Timing
- Reset values:
  - Outputs: `gnt` = 0, `gnt_id` = 0, `gnt_valid` = 0, `timeout` = 0.
  - Internal: state = IDLE, `last_id` = 0, `blocked` = 0, `hold_cnt` = 0.
- Grant latency: a request sampled at edge k gives `gnt` valid after edge k (one-cycle registered latency from request assertion).
- Release latency: owner's `req` sampled low at edge k gives `gnt` = 0 after edge k. The earliest next grant appears after edge k+1, giving one guaranteed dead cycle.
- Timeout: an owner keeping `req` high is granted for exactly `MAX_HOLD` cycles. `timeout` is high only during the following RELEASE cycle.
- Simultaneous events:
  - Owner drops `req` on the same edge as `hold_cnt` = `MAX_HOLD`: treated as a normal release. No `timeout`, no block.
  - `req[i]` low at the same edge that would set `blocked[i]`: cannot occur, since blocking requires `req` high.
- Reset asserted mid-GRANT: all outputs clear immediately (asynchronous). After `rst_n` deassertion, arbitration restarts from IDLE with `last_id` = 0.
- `gnt` is always one-hot or zero. `gnt_valid` = |`gnt`.

## Structure
- Shared package holds:
  - state encoding constants IDLE/GRANT/RELEASE
  - `NREQ` = 8
  - `ID_W` = 3
- One combinational sub-module, `pri_enc8`:
  - input: 8-bit vector
  - outputs: 3-bit index of highest set bit, plus `any`
  - instantiated twice, once on `masked` and once on `elig`.
- Top contains the FSM, `hold_cnt`, `last_id`, `blocked`, and the output registers. Estimated 150–250 lines total.

## Test plan
- Fixed mode, priority: `req` = 8'b0010_0101 held → after the first edge `gnt` = 8'b0010_0000, `gnt_id` = 5. Drop `req[5]` → one dead cycle, then `gnt_id` = 2.
- Round-robin rotation: `rr_en` = 1, `req` = 8'hFF. Each owner drops `req` after 2 cycles and reasserts → grant order 7,6,5,4,3,2,1,0,7, with one dead cycle between grants.
- Timeout: `MAX_HOLD` = 4, `req` = 8'b1000_0001 held constantly → `gnt_id` = 7 for exactly 4 cycles, then `timeout` = 1 for one cycle, then `gnt_id` = 0. Requester 7 is not re-granted until `req[7]` has been low for one cycle.
- Simultaneous release at the limit: `MAX_HOLD` = 4, owner drops `req` on the 4th grant cycle → `timeout` stays 0 and `blocked` stays 0.
- Asynchronous reset: assert `rst_n` = 0 mid-grant between clock edges → `gnt`, `gnt_valid`, `gnt_id` go to 0 without waiting for `clk`. After release with `rr_en` = 1 and `req` = 8'hFF, the first grant is `gnt_id` = 7.
- Mode switch: toggle `rr_en` while a grant is held → the current owner is unaffected. The next winner follows the new mode.
